// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider. Each channel divides clk by N+1
// (pulse mode) or 2(N+1) (toggle mode), with shadowed divisor/mode updates at wrap.
module clk_div_multi #(
   parameter int CH          = 4,
   parameter int W           = 22,
   parameter int DEFAULT_DIV = 50000,
   localparam int CW         = (CH > 1) ? $clog2(CH) : 1
) (
   input  logic          clk,
   input  logic          rst_clk,
   input  logic [CH-1:0] en,
   input  logic          clr,
   input  logic          wr_en,
   input  logic [CW-1:0] wr_ch,
   input  logic [W-1:0]  wr_div,
   input  logic          wr_mode,
   output logic [CH-1:0] div_clk,
   output logic [CH-1:0] tick
);

   for (genvar i = 0; i < CH; i++) begin : g_ch
      logic [W-1:0] shadow_div;
      logic         shadow_mode;
      logic [W-1:0] act_div;
      logic         act_mode;
      logic [W-1:0] cnt;
      logic         div_q;
      logic         tick_q;
      logic         wr_hit;

      // Out-of-range channel numbers never match any i, so they are dropped here.
      assign wr_hit = wr_en && (int'(wr_ch) == i);

      // Active registers reload from shadow only at a wrap or while disabled, so a
      // write coinciding with a wrap only becomes active at the following wrap.
      always_ff @(posedge clk or negedge rst_clk) begin
         if (!rst_clk) begin
            shadow_div  <= W'(DEFAULT_DIV);
            shadow_mode <= 1'b0;
            act_div     <= W'(DEFAULT_DIV);
            act_mode    <= 1'b0;
            cnt         <= '0;
            div_q       <= 1'b0;
            tick_q      <= 1'b0;
         end else begin
            if (wr_hit) begin
               shadow_div  <= wr_div;
               shadow_mode <= wr_mode;
            end
            if (clr) begin
               cnt    <= '0;
               div_q  <= 1'b0;
               tick_q <= 1'b0;
            end else if (!en[i]) begin
               cnt      <= '0;
               div_q    <= 1'b0;
               tick_q   <= 1'b0;
               act_div  <= shadow_div;
               act_mode <= shadow_mode;
            end else if (cnt == act_div) begin
               cnt      <= '0;
               tick_q   <= 1'b1;
               act_div  <= shadow_div;
               act_mode <= shadow_mode;
               // A mode switch restarts the output low rather than mixing rules.
               if (shadow_mode != act_mode) begin
                  div_q <= 1'b0;
               end else if (act_mode) begin
                  div_q <= 1'b1;
               end else begin
                  div_q <= ~div_q;
               end
            end else begin
               cnt    <= cnt + W'(1);
               tick_q <= 1'b0;
               if (act_mode) begin
                  div_q <= 1'b0;
               end
            end
         end
      end

      assign div_clk[i] = div_q;
      assign tick[i]    = tick_q;
   end

endmodule

// File: tb/tb_clk_div_multi.sv
// Self-checking bench for clk_div_multi: a per-cycle vector table for channel 1
// plus directed sequences for wrap-time writes, N=0, clr alignment and reset.
module tb_clk_div_multi;

   localparam int CH = 4;
   localparam int W  = 22;

   logic          clk;
   logic          rst_clk;
   logic [CH-1:0] en;
   logic          clr;
   logic          wr_en;
   logic [1:0]    wr_ch;
   logic [W-1:0]  wr_div;
   logic          wr_mode;
   logic [CH-1:0] div_clk;
   logic [CH-1:0] tick;

   int total;
   int bad;

   typedef struct {
      logic [3:0]   en;
      logic         wr_en;
      logic [1:0]   wr_ch;
      logic [W-1:0] wr_div;
      logic         wr_mode;
      logic         exp_tick;
      logic         exp_div;
   } vec_t;

   vec_t vecs [15];

   clk_div_multi #(.CH(CH), .W(W), .DEFAULT_DIV(50000)) dut (
      .clk     (clk),
      .rst_clk (rst_clk),
      .en      (en),
      .clr     (clr),
      .wr_en   (wr_en),
      .wr_ch   (wr_ch),
      .wr_div  (wr_div),
      .wr_mode (wr_mode),
      .div_clk (div_clk),
      .tick    (tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      en      = v.en;
      wr_en   = v.wr_en;
      wr_ch   = v.wr_ch;
      wr_div  = v.wr_div;
      wr_mode = v.wr_mode;
   endtask

   task automatic writeDiv(input logic [1:0] ch, input logic [W-1:0] n, input logic mode);
      wr_en   = 1'b1;
      wr_ch   = ch;
      wr_div  = n;
      wr_mode = mode;
   endtask

   initial begin
      int cnt_ticks;
      int edges;
      logic [1:0] pat;

      total = 0;
      bad   = 0;

      // ch1: write N=3 toggle while disabled, enable, expect 4-clk tick and 8-clk period
      vecs[0] = '{4'b0000, 1'b1, 2'd1, 22'd3, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{4'b0000, 1'b0, 2'd0, 22'd0, 1'b0, 1'b0, 1'b0};
      for (int k = 0; k < 12; k++) begin
         vecs[2+k].en       = 4'b0010;
         vecs[2+k].wr_en    = 1'b0;
         vecs[2+k].wr_ch    = 2'd0;
         vecs[2+k].wr_div   = '0;
         vecs[2+k].wr_mode  = 1'b0;
         vecs[2+k].exp_tick = ((k % 4) == 3);
         vecs[2+k].exp_div  = (k >= 3 && k <= 6) || (k == 11);
      end
      vecs[14] = '{4'b0000, 1'b0, 2'd0, 22'd0, 1'b0, 1'b0, 1'b0};

      rst_clk = 1'b0;
      en      = '0;
      clr     = 1'b0;
      wr_en   = 1'b0;
      wr_ch   = '0;
      wr_div  = '0;
      wr_mode = 1'b0;
      #23;
      checkOutput("reset_div_clk", 32'(div_clk), 32'h0);
      checkOutput("reset_tick", 32'(tick), 32'h0);
      step();
      rst_clk = 1'b1;
      step();

      for (int i = 0; i < 15; i++) begin
         applyStimulus(vecs[i]);
         step();
         checkOutput($sformatf("vec%0d", i), {30'd0, tick[1], div_clk[1]},
                     {30'd0, vecs[i].exp_tick, vecs[i].exp_div});
      end

      // ch2: N=5 toggle, then write N=2 pulse in the wrap cycle
      writeDiv(2'd2, 22'd5, 1'b0);
      step();
      wr_en = 1'b0;
      step();
      en = 4'b0100;
      for (int k = 0; k < 5; k++) step();
      writeDiv(2'd2, 22'd2, 1'b1);
      step();
      wr_en = 1'b0;
      checkOutput("ch2_first_wrap", {30'd0, tick[2], div_clk[2]}, 32'h3);
      cnt_ticks = 0;
      for (int k = 0; k < 5; k++) begin
         step();
         if (tick[2]) cnt_ticks++;
      end
      checkOutput("ch2_old_period_quiet", 32'(cnt_ticks), 32'h0);
      step();
      checkOutput("ch2_mode_switch_wrap", {30'd0, tick[2], div_clk[2]}, 32'h2);
      for (int k = 0; k < 6; k++) begin
         step();
         pat = ((k % 3) == 2) ? 2'b11 : 2'b00;
         checkOutput($sformatf("ch2_pulse%0d", k), {30'd0, tick[2], div_clk[2]}, {30'd0, pat});
      end
      en = '0;
      step();

      // ch3: N=0 toggle -> tick held high, div_clk toggles every clk
      writeDiv(2'd3, 22'd0, 1'b0);
      step();
      wr_en = 1'b0;
      step();
      en = 4'b1000;
      for (int k = 0; k < 6; k++) begin
         step();
         checkOutput($sformatf("ch3_n0_%0d", k), {30'd0, tick[3], div_clk[3]},
                     {30'd0, 1'b1, ((k % 2) == 0)});
      end
      en = '0;
      step();

      // ch0 N=4, ch1 N=9; clr mid-count must phase-align them
      writeDiv(2'd0, 22'd4, 1'b0);
      step();
      writeDiv(2'd1, 22'd9, 1'b0);
      step();
      wr_en = 1'b0;
      step();
      en = 4'b0011;
      for (int k = 0; k < 7; k++) step();
      clr = 1'b1;
      step();
      clr = 1'b0;
      checkOutput("clr_outputs", {28'd0, tick[1:0], div_clk[1:0]}, 32'h0);
      for (int k = 1; k <= 10; k++) begin
         step();
         pat = (k == 10) ? 2'b11 : ((k == 5) ? 2'b01 : 2'b00);
         checkOutput($sformatf("clr_align_tick%0d", k), {30'd0, tick[1:0]}, {30'd0, pat});
      end
      checkOutput("clr_align_div", {30'd0, div_clk[1:0]}, 32'h2);

      // asynchronous reset between edges, mid-period
      #3;
      rst_clk = 1'b0;
      #1;
      checkOutput("async_reset_div_clk", 32'(div_clk), 32'h0);
      checkOutput("async_reset_tick", 32'(tick), 32'h0);
      #2;
      rst_clk = 1'b1;
      en = 4'b1011;
      cnt_ticks = 0;
      for (int k = 0; k < 200; k++) begin
         step();
         if (tick != 4'b0000) cnt_ticks++;
      end
      checkOutput("post_reset_default_div", 32'(cnt_ticks), 32'h0);
      en = '0;
      step();

      // ch0 at default divisor: first tick and div_clk rise 50001 clk after enable
      en = 4'b0001;
      edges = 0;
      do begin
         step();
         edges++;
      end while (!tick[0] && edges < 60000);
      checkOutput("default_first_tick", 32'(edges), 32'd50001);
      checkOutput("default_first_rise", 32'(div_clk[0]), 32'h1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
